// File: rtl/ssd_scan_scheduler.sv
// Eight-digit seven-segment scan driver with blanking, hex decode,
// leading-zero suppression and frame-aligned double-buffered loads.
module ssd_scan_scheduler #(
  parameter int DIGIT_CYCLES = 131072,
  parameter int BLANK_CYCLES = 1024,
  parameter int CNT_W        = 20
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  enable_in,
  input  logic        blank_zeros_in,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_tick,
  output logic [7:0]  An,
  output logic [7:0]  Cath
);

  typedef enum logic {BLANK, DRIVE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wrap;

  logic [31:0]        pdig_q, sdig_q;
  logic [7:0]         pdp_q, sdp_q;
  logic [7:0]         pen_q, sen_q;
  logic               pbz_q, sbz_q;
  logic               pflag_q;

  logic [7:0]         an_q, an_d;
  logic [7:0]         cath_q, cath_d;
  logic               ack_q, tick_q;

  logic [7:0]         supp;
  logic               zero_above;
  logic               lit;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    unique case (n)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    wrap    = 1'b0;
    unique case (state_q)
      BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_W'(DIGIT_CYCLES - 1)) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          wrap    = (idx_q == 3'd7);
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // A digit is suppressed when it and every digit left of it are zero.
  always_comb begin
    supp       = '0;
    zero_above = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      zero_above = zero_above && (sdig_q[4*i +: 4] == 4'd0);
      supp[i]    = sbz_q && zero_above;
    end
  end

  always_comb begin
    lit    = (state_q == DRIVE) && sen_q[idx_q] && !supp[idx_q];
    an_d   = 8'hFF;
    cath_d = 8'hFF;
    if (lit) begin
      an_d   = ~(8'd1 << idx_q);
      cath_d = {seg7(sdig_q[4*idx_q +: 4]), ~sdp_q[idx_q]};
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state_q <= BLANK;
      idx_q   <= '0;
      cnt_q   <= '0;
      pdig_q  <= '0;
      pdp_q   <= '0;
      pen_q   <= '0;
      pbz_q   <= 1'b0;
      pflag_q <= 1'b0;
      sdig_q  <= '0;
      sdp_q   <= '0;
      sen_q   <= '0;
      sbz_q   <= 1'b0;
      an_q    <= 8'hFF;
      cath_q  <= 8'hFF;
      ack_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      cath_q  <= cath_d;
      tick_q  <= wrap;
      ack_q   <= wrap && pflag_q;
      if (wrap && pflag_q) begin
        sdig_q <= pdig_q;
        sdp_q  <= pdp_q;
        sen_q  <= pen_q;
        sbz_q  <= pbz_q;
      end
      // A load on the boundary cycle re-arms the flag for the next frame.
      if (load) begin
        pdig_q  <= digits_in;
        pdp_q   <= dp_in;
        pen_q   <= enable_in;
        pbz_q   <= blank_zeros_in;
        pflag_q <= 1'b1;
      end else if (wrap) begin
        pflag_q <= 1'b0;
      end
    end
  end

  assign An         = an_q;
  assign Cath       = cath_q;
  assign load_ack   = ack_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Scoreboard bench for ssd_scan_scheduler: a position-in-frame model
// predicts every output cycle; a negedge monitor compares.
module tb_ssd_scan_scheduler;

  localparam int DC    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = DC + BC;
  localparam int FRAME = 8 * SLOT;

  logic        ClkPort = 1'b0;
  logic        Reset;
  logic [31:0] digits_in;
  logic [7:0]  dp_in;
  logic [7:0]  enable_in;
  logic        blank_zeros_in;
  logic        load;
  logic        load_ack;
  logic        frame_tick;
  logic [7:0]  An;
  logic [7:0]  Cath;

  ssd_scan_scheduler #(
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC),
    .CNT_W(20)
  ) dut (
    .ClkPort(ClkPort),
    .Reset(Reset),
    .digits_in(digits_in),
    .dp_in(dp_in),
    .enable_in(enable_in),
    .blank_zeros_in(blank_zeros_in),
    .load(load),
    .load_ack(load_ack),
    .frame_tick(frame_tick),
    .An(An),
    .Cath(Cath)
  );

  always #5 ClkPort = ~ClkPort;

  typedef struct {
    int         k;
    logic [7:0] an;
    logic [7:0] cath;
    logic       tick;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   k = 0;

  logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic [31:0] m_dig, p_dig;
  logic [7:0]  m_dp, p_dp, m_en, p_en;
  logic        m_bz, p_bz, p_flag;

  // What the display shows while the frame is at position pos.
  function automatic logic [15:0] view(input int pos);
    int s, r;
    logic [3:0] nib;
    logic supp;
    s = pos / SLOT;
    r = pos % SLOT;
    if (r < BC) return 16'hFFFF;
    nib  = 4'((m_dig >> (4 * s)) & 32'hF);
    supp = m_bz && (s > 0) && ((m_dig >> (4 * s)) == 32'd0);
    if (!m_en[s] || supp) return 16'hFFFF;
    return {~(8'd1 << s), SEG[nib], ~m_dp[s]};
  endfunction

  always @(posedge ClkPort) begin
    exp_t e;
    logic [15:0] v;
    if (Reset) begin
      k = 0;
      m_dig = '0; m_dp = '0; m_en = '0; m_bz = 1'b0;
      p_flag = 1'b0;
      sb.delete();
    end else begin
      k++;
      v      = view((k - 1) % FRAME);
      e.k    = k;
      e.an   = v[15:8];
      e.cath = v[7:0];
      e.tick = (k % FRAME == 0);
      e.ack  = e.tick && p_flag;
      if (e.ack) begin
        m_dig = p_dig; m_dp = p_dp; m_en = p_en; m_bz = p_bz;
        p_flag = 1'b0;
      end
      if (load) begin
        p_dig = digits_in; p_dp = dp_in;
        p_en = enable_in; p_bz = blank_zeros_in;
        p_flag = 1'b1;
      end
      sb.push_back(e);
    end
  end

  always @(negedge ClkPort) begin
    exp_t e;
    if (!Reset && sb.size() > 0) begin
      e = sb.pop_front();
      nvec++;
      if (An !== e.an || Cath !== e.cath ||
          frame_tick !== e.tick || load_ack !== e.ack) begin
        nerr++;
        $display("FAIL cycle%0d An/Cath/tick/ack got %h/%h/%b/%b want %h/%h/%b/%b",
                 e.k, An, Cath, frame_tick, load_ack,
                 e.an, e.cath, e.tick, e.ack);
      end
    end
  end

  task automatic tick();
    @(posedge ClkPort);
    #1;
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp,
                         input logic [7:0] en, input logic bz);
    digits_in      = d;
    dp_in          = dp;
    enable_in      = en;
    blank_zeros_in = bz;
    load           = 1'b1;
    tick();
    load           = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    bit found = 1'b0;
    for (int i = 0; i <= FRAME; i++) begin
      if (k % FRAME == p) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) begin
      nerr++;
      $display("FAIL wait_pos got k=%0d want pos %0d", k, p);
    end
  endtask

  task automatic reset_mid();
    @(negedge ClkPort);
    #1 Reset = 1'b1;
    #1;
    nvec++;
    if (An !== 8'hFF || Cath !== 8'hFF) begin
      nerr++;
      $display("FAIL async_reset An/Cath got %h/%h want ff/ff", An, Cath);
    end
    repeat (3) @(posedge ClkPort);
    @(negedge ClkPort);
    #1 Reset = 1'b0;
  endtask

  initial begin
    Reset          = 1'b1;
    load           = 1'b0;
    digits_in      = '0;
    dp_in          = '0;
    enable_in      = '0;
    blank_zeros_in = 1'b0;
    repeat (3) @(posedge ClkPort);
    @(negedge ClkPort);
    #1 Reset = 1'b0;

    repeat (100) tick();

    do_load(32'h00000012, 8'h01, 8'h03, 1'b0);
    repeat (110) tick();

    do_load(32'h00000105, 8'h00, 8'hFF, 1'b1);
    repeat (110) tick();

    wait_pos(10);
    do_load(32'h1, 8'h00, 8'hFF, 1'b0);
    repeat (5) tick();
    do_load(32'h7, 8'h00, 8'hFF, 1'b0);
    wait_pos(FRAME - 1);
    do_load(32'h3, 8'h00, 8'hFF, 1'b0);
    repeat (110) tick();

    wait_pos(3);
    do_load(32'h0000ABCD, 8'hF0, 8'hFF, 1'b0);
    wait_pos(2 * SLOT + BC + 1);
    reset_mid();
    repeat (60) tick();

    do_load(32'h76543210, 8'h00, 8'hFF, 1'b0);
    repeat (110) tick();

    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 70)) tick();
      do_load($urandom >> (4 * $urandom_range(0, 7)),
              8'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0)
        do_load($urandom >> (4 * $urandom_range(0, 7)),
                8'($urandom), 8'($urandom), 1'($urandom));
    end
    repeat (2 * FRAME) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
